// File: rtl/viterbi_frame_sched.sv
// viterbi_frame_sched: shares one free-running Viterbi decoder between NCH
// channels, one whole frame at a time, granted in round-robin order. Each
// frame is clear (IDLE) -> FRAME_LEN symbol pairs (RUN) -> DRAIN zero pairs,
// and the decoded bits coming back are tagged with the granted channel.
module viterbi_frame_sched #(
    parameter int NCH       = 2,
    parameter int FRAME_LEN = 64,
    parameter int DRAIN     = 8,
    parameter int DEC_LAT   = 8,
    localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CNTW     = $clog2(FRAME_LEN + DRAIN + DEC_LAT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   ch_req,
    input  logic [2*NCH-1:0] ch_code,
    input  logic [NCH-1:0]   ch_valid,
    output logic [NCH-1:0]   ch_ready,
    output logic             dec_clr,
    output logic [1:0]       dec_code,
    input  logic             dec_out,
    output logic             out_bit,
    output logic             out_valid,
    output logic [CW-1:0]    out_ch,
    output logic             frame_done,
    output logic             underrun,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    // Offsets are counted from the first RUN cycle and run through DRAIN.
    localparam logic [CNTW-1:0] RUN_LAST   = CNTW'(FRAME_LEN - 1);
    localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'(FRAME_LEN + DRAIN - 1);
    localparam logic [CNTW-1:0] CAP_FIRST  = CNTW'(DEC_LAT);
    localparam logic [CNTW-1:0] CAP_LAST   = CNTW'(DEC_LAT + FRAME_LEN - 1);

    state_t          state;
    logic [CW-1:0]   gnt;
    logic [CW-1:0]   rr_ptr;
    logic [CNTW-1:0] cnt;

    logic            pick_found;
    logic [CW-1:0]   pick_idx;
    logic [CW-1:0]   rr_next;
    logic [CW:0]     cand;
    logic [CW:0]     nxt;
    logic [1:0]      sel_code;
    logic            sel_valid;

    // Round-robin arbiter: first requester at or after rr_ptr, wrapping mod NCH.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = {1'b0, rr_ptr} + (CW+1)'(i);
            if (cand >= (CW+1)'(NCH)) begin
                cand = cand - (CW+1)'(NCH);
            end
            if (!pick_found && ch_req[cand[CW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[CW-1:0];
            end
        end
        nxt = {1'b0, pick_idx} + (CW+1)'(1);
        if (nxt == (CW+1)'(NCH)) begin
            nxt = '0;
        end
        rr_next = nxt[CW-1:0];
    end

    // Select the granted channel's symbol pair and its valid flag.
    always_comb begin
        sel_code  = 2'b00;
        sel_valid = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt == CW'(k)) begin
                sel_code  = ch_code[2*k +: 2];
                sel_valid = ch_valid[k];
            end
        end
    end

    // A missing symbol still consumes a decoder cycle, so it is fed as zeros.
    assign dec_code = (state == S_RUN && sel_valid) ? sel_code : 2'b00;

    // Frame FSM with registered control outputs and decoded-bit capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            gnt        <= '0;
            rr_ptr     <= '0;
            cnt        <= '0;
            ch_ready   <= '0;
            dec_clr    <= 1'b1;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        state    <= S_RUN;
                        gnt      <= pick_idx;
                        rr_ptr   <= rr_next;
                        cnt      <= '0;
                        underrun <= 1'b0;
                        ch_ready <= NCH'(1) << pick_idx;
                        dec_clr  <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNTW'(1);
                    if (!sel_valid) begin
                        underrun <= 1'b1;
                    end
                    if (cnt == RUN_LAST) begin
                        state    <= S_DRAIN;
                        ch_ready <= '0;
                    end
                end
                S_DRAIN: begin
                    cnt <= cnt + CNTW'(1);
                    if (cnt == DRAIN_LAST) begin
                        state   <= S_IDLE;
                        dec_clr <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ch_ready <= '0;
                    dec_clr  <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase

            if (state != S_IDLE && cnt >= CAP_FIRST && cnt <= CAP_LAST) begin
                out_bit    <= dec_out;
                out_ch     <= gnt;
                out_valid  <= 1'b1;
                frame_done <= (cnt == CAP_LAST);
            end else begin
                out_valid  <= 1'b0;
                frame_done <= 1'b0;
            end
        end
    end

endmodule

// File: doc/viterbi_frame_sched.md
# viterbi_frame_sched

Frame-level scheduler that time-shares one free-running 16-state, rate-1/2 Viterbi decoder between NCH coded-symbol channels. It grants the decoder to one channel per frame in round-robin order. Each frame runs as clear → feed FRAME_LEN symbol pairs → flush with zero symbols. The decoded bits are tagged with the channel index on the output side. It sits between the per-channel frame buffers and the decoder, and drives the decoder's reset and code inputs.

## Interface
- NCH, 2: number of requesting channels (2..4).
- FRAME_LEN, 64: symbol pairs per frame (≥ 2).
- DRAIN, 8: zero-symbol flush cycles after each frame. Must be ≥ DEC_LAT.
- DEC_LAT, 8: cycles from a symbol on dec_code to its decoded bit on dec_out.
- CW: derived, max(1, clog2(NCH)).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ch_req  in  NCH  channel k holds a complete frame ready to stream.
- ch_code  in  2*NCH  symbol pair of channel k at bits [2k+1:2k].
- ch_valid  in  NCH  symbol on ch_code[k] valid this cycle.
- ch_ready  out  NCH  one-hot; symbol of granted channel consumed this cycle.
- dec_clr  out  1  decoder clear (active-high; the top level inverts it for the decoder's rst_n).
- dec_code  out  2  symbol pair to the decoder.
- dec_out  in  1  decoded bit from the decoder.
- out_bit  out  1  registered decoded bit.
- out_valid  out  1  out_bit is valid.
- out_ch  out  CW  channel index of out_bit.
- frame_done  out  1  one-cycle pulse on the last out_valid of a frame.
- underrun  out  1  sticky per frame; granted channel had ch_valid=0 during RUN.
- busy  out  1  state ≠ IDLE.

## Operation
- **State machine**: IDLE, RUN, DRAIN. All are registered. The symbol counter is clog2(FRAME_LEN+DRAIN+DEC_LAT)+1 bits wide.
- **IDLE**
  - dec_clr=1, dec_code=00, ch_ready=0.
  - If any ch_req is set, pick the first requester at or after rr_ptr, cycling upward mod NCH.
  - Latch the winner as gnt, set rr_ptr=(gnt+1) mod NCH, clear underrun, and go to RUN next cycle.
  - If no requests, stay in IDLE. Every frame is preceded by ≥ 1 IDLE cycle, so the decoder is cleared between frames.
- **RUN**: lasts exactly FRAME_LEN cycles.
  - dec_clr=0, ch_ready[gnt]=1, dec_code=ch_code[gnt] (combinational mux).
  - If ch_valid[gnt]=0: dec_code=00, underrun←1, and the cycle still counts. There is no stall, because the decoder is free-running.
  - ch_req changes during RUN/DRAIN are ignored and gnt is held.
- **DRAIN**: lasts exactly DRAIN cycles. dec_clr=0, dec_code=00, ch_ready=0. Then return to IDLE.
- **Output capture**
  - Let offset 0 be the first RUN cycle.
  - At offsets DEC_LAT … DEC_LAT+FRAME_LEN−1, register out_bit←dec_out, out_ch←gnt, out_valid←1. Otherwise out_valid←0.
  - frame_done←1 together with the final out_valid.
- **Round-robin rules**
  - rr_ptr is CW bits and resets to 0.
  - A continuously requesting channel waits at most NCH−1 frames.
- **Reset**
  - Asserting rst in any state aborts the frame immediately.
  - Outputs on reset: state=IDLE, dec_clr=1, dec_code=00, ch_ready=0, out_bit=0, out_valid=0, out_ch=0, frame_done=0, underrun=0, busy=0, rr_ptr=0.
  - Partial frame output is discarded. No out_valid appears after reset until a new grant.

## Timing
- Grant latency: ch_req seen in IDLE at cycle t gives RUN starting at t+1.
- Frame period under back-to-back requests: FRAME_LEN+DRAIN+1 cycles.
- out_valid is high for FRAME_LEN consecutive cycles, at offsets DEC_LAT+1 … DEC_LAT+FRAME_LEN.
- The last out_valid falls no later than the IDLE cycle that follows DRAIN (guaranteed by DRAIN ≥ DEC_LAT). Outputs of consecutive frames never overlap.
- underrun is valid from the cycle after the offending RUN cycle until the next grant.

## Test plan
All scenarios use NCH=2, FRAME_LEN=8, DRAIN=4, DEC_LAT=3.

1. **Reset values**: rst high, then low, with no requests → dec_clr=1, busy=0, out_valid=0, ch_ready=00, and all outputs stay at their reset values indefinitely.
2. **Single frame**: ch_req=01 at cycle 0, ch_valid held high → RUN cycles 1–8 with ch_ready=01; DRAIN cycles 9–12 with dec_code=00; out_valid cycles 5–12 with out_ch=0 and out_bit equal to dec_out delayed one cycle; frame_done at cycle 12; IDLE with dec_clr=1 at cycle 13.
3. **Round-robin**: ch_req=11 held → grants 0,1,0,1 with RUN starting at cycles 1, 14, 27, 40; ≥ 1 IDLE cycle with dec_clr=1 between frames.
4. **Underrun**: ch_valid[0] low in RUN cycle 4 only → dec_code=00 that cycle; underrun=1 from cycle 5; frame length unchanged (frame_done still at 12); underrun cleared at the next grant.
5. **Reset mid-frame**: rst pulsed at cycle 6 of scenario 2 → next cycle shows IDLE, dec_clr=1, out_valid=0; rr_ptr=0, so with ch_req=11 re-asserted the next grant goes to ch0.
6. **Request change ignored**: ch_req[0] dropped at cycle 3 of a ch0 frame while ch_req[1] rises → the ch0 frame completes all 8 symbols, and ch1 is granted at cycle 14.
